// File: rtl/rx_pkt_pkg.sv
// rx_pkt_pkg -- shared definitions for the radio-packet line writer.
//   state_t         : packet FSM states (also exported on the debug port)
//   PIX_W           : pixel width (12)
//   ADDR_W          : line address width (16)
//   DEF_PIX_PER_PKT : default pixels per radio packet
//   PIX_IDX_W       : width of the in-packet pixel index (covers 0..254)
package rx_pkt_pkg;

  localparam int PIX_W           = 12;
  localparam int ADDR_W          = 16;
  localparam int DEF_PIX_PER_PKT = 16;
  localparam int PIX_IDX_W       = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_DATA  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ABORT = 3'd4
  } state_t;

endpackage

// File: rtl/rx_pkt_writer_if.sv
// rx_pkt_writer_if -- receive-side strobes and memory write port of the
// packet writer.
//   rx_data/rx_valid         : pixel and its strobe
//   rx_header                : header phase level (edges are meaningful)
//   rx_add/rx_add_valid      : line address and its strobe
//   frame_sync               : frame correlation level (rising edge used)
//   mem_we/mem_addr/mem_wdata: one-cycle write of a packed pixel pair
// Handshake: every *_valid / mem_we is a single-cycle qualifier sampled on
// the rising clk edge; there is no ready/backpressure in either direction,
// so a strobe is consumed (or dropped) in the cycle it is presented.
// modport master = packet source / memory sink, slave = the writer.
interface rx_pkt_writer_if #(
  parameter int WORD_IDX_W = 3
);
  logic [rx_pkt_pkg::PIX_W-1:0]             rx_data;
  logic                                     rx_valid;
  logic                                     rx_header;
  logic [rx_pkt_pkg::ADDR_W-1:0]            rx_add;
  logic                                     rx_add_valid;
  logic                                     frame_sync;
  logic                                     mem_we;
  logic [rx_pkt_pkg::ADDR_W+WORD_IDX_W-1:0] mem_addr;
  logic [2*rx_pkt_pkg::PIX_W-1:0]           mem_wdata;

  modport master (
    output rx_data, rx_valid, rx_header, rx_add, rx_add_valid, frame_sync,
    input  mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  rx_data, rx_valid, rx_header, rx_add, rx_add_valid, frame_sync,
    output mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rx_pix_pack.sv
// rx_pix_pack -- pairs consecutive pixels into 24-bit memory words.
//   pixValid/pixIdx/pixData : accepted pixel, its index within the packet
//   line                    : current line address (upper memory address)
//   flush                   : drop a held even pixel (packet aborted)
//   memWe/memAddr/memWdata  : registered write, one clk after the odd pixel
module rx_pix_pack
  import rx_pkt_pkg::*;
#(
  parameter int WORD_IDX_W = 3
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         pixValid,
  input  logic [PIX_IDX_W-1:0]         pixIdx,
  input  logic [PIX_W-1:0]             pixData,
  input  logic [ADDR_W-1:0]            line,
  input  logic                         flush,
  output logic                         memWe,
  output logic [ADDR_W+WORD_IDX_W-1:0] memAddr,
  output logic [2*PIX_W-1:0]           memWdata
);

  logic [PIX_W-1:0] evenQ;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      evenQ    <= '0;
      memWe    <= 1'b0;
      memAddr  <= '0;
      memWdata <= '0;
    end else begin
      memWe <= 1'b0;
      if (flush) begin
        evenQ <= '0;
      end else if (pixValid) begin
        if (!pixIdx[0]) begin
          evenQ <= pixData;
        end else begin
          // Word index is the pair number; odd pixel goes in the upper half.
          memWe    <= 1'b1;
          memAddr  <= {line, WORD_IDX_W'(pixIdx >> 1)};
          memWdata <= {pixData, evenQ};
        end
      end
    end
  end

endmodule

// File: rtl/rx_pkt_writer.sv
// rx_pkt_writer -- writes radio-packet pixels of one image line to memory.
//   clk, rstn   : clock, asynchronous active-low reset
//   bus         : rx_pkt_writer_if.slave (rx strobes in, memory write out)
//   line_done   : one-cycle pulse per complete packet
//   line_addr   : line address of the last completed packet
//   frame_start : one pulse per packet on a frame_sync rise seen in HDR
//   pkt_count   : completed packets (wraps), err_count: aborts (saturates)
//   dbgState    : current FSM state
// Build option: RX_PKT_WRITER_STATS_EN enables pkt_count/err_count; without
// it both ports read 0 and no counter logic exists.
module rx_pkt_writer
  import rx_pkt_pkg::*;
#(
  parameter int PIX_PER_PKT = DEF_PIX_PER_PKT,
  parameter int WORD_IDX_W  = 3,
  parameter int TIMEOUT     = 4096
) (
  input  logic                clk,
  input  logic                rstn,
  rx_pkt_writer_if.slave      bus,
  output logic                line_done,
  output logic [ADDR_W-1:0]   line_addr,
  output logic                frame_start,
  output logic [15:0]         pkt_count,
  output logic [15:0]         err_count,
  output state_t              dbgState
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  state_t               state, stateNxt;
  logic                 hdrQ, syncQ, hdrRise, hdrFall, syncRise;
  logic [ADDR_W-1:0]    line;
  logic [PIX_IDX_W-1:0] pixIdx;
  logic [IDLE_W-1:0]    idleCnt;
  logic                 reHdr, fsSeen;
  logic                 pixAccept, pixLast, idleExpired, flush;

  assign hdrRise  = bus.rx_header & ~hdrQ;
  assign hdrFall  = ~bus.rx_header & hdrQ;
  assign syncRise = bus.frame_sync & ~syncQ;
  assign dbgState = state;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= stateNxt;
  end

  // Next-state logic
  always_comb begin
    stateNxt = state;
    unique case (state)
      ST_IDLE:  if (hdrRise) stateNxt = ST_HDR;
      ST_HDR: begin
        if (bus.rx_add_valid) stateNxt = ST_DATA;
        else if (hdrFall)     stateNxt = ST_ABORT;
      end
      ST_DATA: begin
        if (hdrRise)          stateNxt = ST_ABORT;
        else if (pixLast)     stateNxt = ST_DONE;
        else if (idleExpired) stateNxt = ST_ABORT;
      end
      // A header rising during the DONE/ABORT cycle must not be lost.
      ST_DONE:  stateNxt = hdrRise ? ST_HDR : ST_IDLE;
      ST_ABORT: stateNxt = (reHdr || hdrRise) ? ST_HDR : ST_IDLE;
      default:  stateNxt = ST_IDLE;
    endcase
  end

  // Output / qualifier logic
  always_comb begin
    pixAccept   = 1'b0;
    pixLast     = 1'b0;
    idleExpired = 1'b0;
    flush       = 1'b0;
    line_done   = 1'b0;
    unique case (state)
      ST_DATA: begin
        // A header rise pre-empts the pixel in the same cycle.
        pixAccept   = bus.rx_valid && !hdrRise;
        pixLast     = pixAccept && (pixIdx == PIX_IDX_W'(PIX_PER_PKT - 1));
        idleExpired = !bus.rx_valid && (idleCnt == IDLE_W'(TIMEOUT - 1));
      end
      ST_DONE:  line_done = 1'b1;
      ST_ABORT: flush     = 1'b1;
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hdrQ        <= 1'b0;
      syncQ       <= 1'b0;
      line        <= '0;
      pixIdx      <= '0;
      idleCnt     <= '0;
      reHdr       <= 1'b0;
      fsSeen      <= 1'b0;
      frame_start <= 1'b0;
      line_addr   <= '0;
    end else begin
      hdrQ        <= bus.rx_header;
      syncQ       <= bus.frame_sync;
      reHdr       <= (state == ST_DATA) && hdrRise;
      frame_start <= 1'b0;

      if (state == ST_HDR) begin
        pixIdx <= '0;
        if (bus.rx_add_valid) line <= bus.rx_add;
        if (syncRise && !fsSeen) begin
          frame_start <= 1'b1;
          fsSeen      <= 1'b1;
        end
      end else begin
        fsSeen <= 1'b0;
        if (pixAccept) pixIdx <= pixIdx + 1'b1;
      end

      if (state != ST_DATA || bus.rx_valid) idleCnt <= '0;
      else                                  idleCnt <= idleCnt + 1'b1;

      // line_addr changes on the edge that raises line_done.
      if (pixLast) line_addr <= line;
    end
  end

`ifdef RX_PKT_WRITER_STATS_EN
  logic [15:0] pktCnt, errCnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pktCnt <= '0;
      errCnt <= '0;
    end else begin
      if (pixLast) pktCnt <= pktCnt + 1'b1;
      if (state == ST_ABORT && errCnt != 16'hFFFF) errCnt <= errCnt + 1'b1;
    end
  end

  assign pkt_count = pktCnt;
  assign err_count = errCnt;
`else
  assign pkt_count = '0;
  assign err_count = '0;
`endif

  rx_pix_pack #(
    .WORD_IDX_W (WORD_IDX_W)
  ) u_pack (
    .clk      (clk),
    .rstn     (rstn),
    .pixValid (pixAccept),
    .pixIdx   (pixIdx),
    .pixData  (bus.rx_data),
    .line     (line),
    .flush    (flush),
    .memWe    (bus.mem_we),
    .memAddr  (bus.mem_addr),
    .memWdata (bus.mem_wdata)
  );

endmodule

// File: tb/tb_rx_pkt_writer.sv
// tb_rx_pkt_writer -- directed bench for rx_pkt_writer with a write
// scoreboard. Expected counter values follow RX_PKT_WRITER_STATS_EN.
module tb_rx_pkt_writer;
  import rx_pkt_pkg::*;

  localparam int WIW = 3;
  localparam int WW  = ADDR_W + WIW + 2 * PIX_W;
`ifdef RX_PKT_WRITER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // Clock / reset
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  rx_pkt_writer_if #(.WORD_IDX_W(WIW)) bus ();

  logic              line_done, frame_start;
  logic [ADDR_W-1:0] line_addr;
  logic [15:0]       pkt_count, err_count;
  state_t            dbg_state;

  rx_pkt_writer #(
    .PIX_PER_PKT (16),
    .WORD_IDX_W  (WIW),
    .TIMEOUT     (4096)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .bus         (bus),
    .line_done   (line_done),
    .line_addr   (line_addr),
    .frame_start (frame_start),
    .pkt_count   (pkt_count),
    .err_count   (err_count),
    .dbgState    (dbg_state)
  );

  // Scoreboard
  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] exp_w;
  int            n_checks = 0;
  int            n_pass   = 0;
  int            n_writes = 0;
  int            n_line_done = 0;
  int            n_frame_start = 0;
  logic [23:0]   first_wdata = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      if (n_writes == 0) first_wdata = bus.mem_wdata;
      n_writes++;
      if (exp_q.size() == 0) begin
        check("write_unexpected", 64'({bus.mem_addr, bus.mem_wdata}), 64'd0);
      end else begin
        exp_w = exp_q.pop_front();
        check("write", 64'({bus.mem_addr, bus.mem_wdata}), 64'(exp_w));
      end
    end
    if (line_done === 1'b1)   n_line_done++;
    if (frame_start === 1'b1) n_frame_start++;
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    n_writes      = 0;
    n_line_done   = 0;
    n_frame_start = 0;
  endtask

  task automatic send_header(input logic [15:0] addr);
    bus.rx_header    = 1'b1;
    tick();
    bus.rx_add       = addr;
    bus.rx_add_valid = 1'b1;
    bus.rx_header    = 1'b0;
    tick();
    bus.rx_add_valid = 1'b0;
  endtask

  // Pixel i carries base+i; each odd pixel completes the word {pix[i], pix[i-1]}.
  task automatic send_pixels(input int n, input logic [11:0] base, input logic [15:0] line,
                             input bool_exp);
    for (int i = 0; i < n; i++) begin
      bus.rx_data  = base + 12'(i);
      bus.rx_valid = 1'b1;
      if (bool_exp != 0 && (i % 2) == 1)
        exp_q.push_back({line, WIW'(i >> 1), base + 12'(i), base + 12'(i - 1)});
      tick();
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_we"},      64'(bus.mem_we), 64'd0);
    check({tag, "_mem_addr"},    64'(bus.mem_addr), 64'd0);
    check({tag, "_mem_wdata"},   64'(bus.mem_wdata), 64'd0);
    check({tag, "_line_done"},   64'(line_done), 64'd0);
    check({tag, "_line_addr"},   64'(line_addr), 64'd0);
    check({tag, "_frame_start"}, 64'(frame_start), 64'd0);
    check({tag, "_pkt_count"},   64'(pkt_count), 64'd0);
    check({tag, "_err_count"},   64'(err_count), 64'd0);
    check({tag, "_state"},       64'(dbg_state), 64'(ST_IDLE));
  endtask

  int exp_pkt, exp_err;

  initial begin
    rstn             = 1'b0;
    bus.rx_data      = '0;
    bus.rx_valid     = 1'b0;
    bus.rx_header    = 1'b0;
    bus.rx_add       = '0;
    bus.rx_add_valid = 1'b0;
    bus.frame_sync   = 1'b0;
    exp_pkt          = 0;
    exp_err          = 0;
    #2;
    check_reset_outputs("reset");
    tick();
    tick();
    rstn = 1'b1;
    tick();

    // Full packet, line 0x0012, pixels 0x001..0x010
    clear_stats();
    send_header(16'h0012);
    send_pixels(16, 12'h001, 16'h0012, 1);
    repeat (3) tick();
    exp_pkt++;
    check("t1_writes", 64'(n_writes), 64'd8);
    check("t1_first_wdata", 64'(first_wdata), 64'h002001);
    check("t1_line_done", 64'(n_line_done), 64'd1);
    check("t1_line_addr", 64'(line_addr), 64'h0012);
    check("t1_pkt_count", 64'(pkt_count), STATS ? 64'(exp_pkt) : 64'd0);
    check("t1_state", 64'(dbg_state), 64'(ST_IDLE));
    check("t1_pending", 64'(exp_q.size()), 64'd0);

    // Five pixels then silence: timeout abort, fifth pixel never written
    clear_stats();
    send_header(16'h0100);
    send_pixels(5, 12'h0A1, 16'h0100, 1);
    repeat (4096 + 8) tick();
    exp_err++;
    check("t2_writes", 64'(n_writes), 64'd2);
    check("t2_err_count", 64'(err_count), STATS ? 64'(exp_err) : 64'd0);
    check("t2_line_done", 64'(n_line_done), 64'd0);
    check("t2_line_addr", 64'(line_addr), 64'h0012);
    check("t2_state", 64'(dbg_state), 64'(ST_IDLE));
    check("t2_pending", 64'(exp_q.size()), 64'd0);

    // Pixels with no header are ignored
    clear_stats();
    send_pixels(3, 12'h555, 16'h0000, 0);
    repeat (2) tick();
    check("idle_pix_writes", 64'(n_writes), 64'd0);

    // frame_sync in HDR: one pulse for two rises; address+pixel same cycle
    clear_stats();
    bus.rx_header = 1'b1;
    tick();
    check("t3_state_hdr", 64'(dbg_state), 64'(ST_HDR));
    bus.frame_sync = 1'b1; tick();
    bus.frame_sync = 1'b0; tick();
    bus.frame_sync = 1'b1; tick();
    bus.frame_sync = 1'b0; tick();
    check("t3_frame_start", 64'(n_frame_start), 64'd1);
    bus.rx_add       = 16'h0033;
    bus.rx_add_valid = 1'b1;
    bus.rx_header    = 1'b0;
    bus.rx_data      = 12'hFFF;
    bus.rx_valid     = 1'b1;
    tick();
    bus.rx_add_valid = 1'b0;
    bus.rx_valid     = 1'b0;
    send_pixels(16, 12'h200, 16'h0033, 1);
    repeat (3) tick();
    exp_pkt++;
    check("t3_writes", 64'(n_writes), 64'd8);
    check("t3_line_addr", 64'(line_addr), 64'h0033);
    check("t3_pkt_count", 64'(pkt_count), STATS ? 64'(exp_pkt) : 64'd0);
    check("t3_frame_start_total", 64'(n_frame_start), 64'd1);

    // New header after pixel 9: abort, then a normal packet
    clear_stats();
    send_header(16'h0044);
    send_pixels(9, 12'h400, 16'h0044, 1);
    bus.rx_header = 1'b1;
    tick();
    check("t4_state_abort", 64'(dbg_state), 64'(ST_ABORT));
    tick();
    check("t4_state_hdr", 64'(dbg_state), 64'(ST_HDR));
    bus.rx_add       = 16'h0055;
    bus.rx_add_valid = 1'b1;
    bus.rx_header    = 1'b0;
    tick();
    bus.rx_add_valid = 1'b0;
    send_pixels(16, 12'h500, 16'h0055, 1);
    repeat (3) tick();
    exp_err++;
    exp_pkt++;
    check("t4_writes", 64'(n_writes), 64'd12);
    check("t4_err_count", 64'(err_count), STATS ? 64'(exp_err) : 64'd0);
    check("t4_pkt_count", 64'(pkt_count), STATS ? 64'(exp_pkt) : 64'd0);
    check("t4_line_done", 64'(n_line_done), 64'd1);
    check("t4_line_addr", 64'(line_addr), 64'h0055);
    check("t4_pending", 64'(exp_q.size()), 64'd0);

    // Reset after pixel 7, then a clean packet
    clear_stats();
    send_header(16'h0066);
    send_pixels(8, 12'h300, 16'h0066, 1);
    tick();
    rstn = 1'b0;
    #1;
    check_reset_outputs("t5_reset");
    tick();
    rstn = 1'b1;
    tick();
    check("t5_writes_before", 64'(n_writes), 64'd4);
    clear_stats();
    exp_pkt = 0;
    exp_err = 0;
    send_header(16'h0077);
    send_pixels(16, 12'h700, 16'h0077, 1);
    repeat (3) tick();
    exp_pkt++;
    check("t5_writes", 64'(n_writes), 64'd8);
    check("t5_err_count", 64'(err_count), 64'd0);
    check("t5_pkt_count", 64'(pkt_count), STATS ? 64'(exp_pkt) : 64'd0);
    check("t5_line_addr", 64'(line_addr), 64'h0077);
    check("t5_pending", 64'(exp_q.size()), 64'd0);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rx_pkt_writer.md
RX_PKT_WRITER -- requirements
Module: rx_pkt_writer

Interface
REQ-001 SHALL have parameter PIX_PER_PKT, default 16, meaning 12-bit pixels per radio packet; even, 2..254.
REQ-002 SHALL have parameter WORD_IDX_W, default 3, meaning word-index width within a packet; 2^WORD_IDX_W >= PIX_PER_PKT/2.
REQ-003 SHALL have parameter TIMEOUT, default 4096, meaning idle clk cycles tolerated in DATA.
REQ-004 clk  in  1  clock; rstn  in  1  reset, asynchronous, active-low.
REQ-005 rx_data  in  12  pixel; rx_valid  in  1  pixel strobe; rx_header  in  1  header phase.
REQ-006 rx_add  in  16  line address; rx_add_valid  in  1  address strobe; frame_sync  in  1  frame correlation hit.
REQ-007 mem_we  out  1; mem_addr  out  16+WORD_IDX_W  {line, word_idx}; mem_wdata  out  24  {pix_odd, pix_even}.
REQ-008 line_done  out  1  pulse per complete packet; line_addr  out  16  last completed line; frame_start  out  1  pulse.
REQ-009 pkt_count  out  16; err_count  out  16.

Function
REQ-010 SHALL implement FSM IDLE, HDR, DATA, DONE, ABORT.
REQ-011 IDLE->HDR on rx_header rising edge.
REQ-012 HDR: rx_add_valid latches rx_add into line register and moves to DATA with pixel index 0.
REQ-013 HDR: rx_header falling without rx_add_valid moves to ABORT.
REQ-014 DATA: each rx_valid stores the even-index pixel in a holding register; an odd-index pixel issues mem_we for 1 cycle, registered one clk after that strobe.
REQ-015 mem_addr SHALL equal {line, pixel_index>>1}; mem_wdata[11:0] SHALL hold the even pixel, mem_wdata[23:12] the odd pixel.
REQ-016 DATA->DONE when pixel index reaches PIX_PER_PKT; extra rx_valid in DONE/IDLE SHALL be ignored.
REQ-017 DONE: one-cycle line_done, line_addr updated with the same edge, pkt_count+1 (wraps at 0xFFFF), then IDLE.
REQ-018 DATA: idle counter resets on each rx_valid; reaching TIMEOUT moves to ABORT.
REQ-019 DATA: rx_header rising moves to ABORT, with the next HDR entered one cycle later.
REQ-020 ABORT: err_count+1 (saturates at 0xFFFF), a pending even pixel is discarded (no write), no line_done, then IDLE (or HDR per REQ-019), one cycle.
REQ-021 frame_start SHALL pulse once on a frame_sync rising edge seen while in HDR; later edges in the same packet are ignored.
REQ-022 rx_valid and rx_add_valid in the same cycle in HDR: address accepted, pixel dropped.

Reset
REQ-023 rstn low SHALL force IDLE, mem_we=0, mem_addr=0, mem_wdata=0, line_done=0, line_addr=0, frame_start=0, pkt_count=0, err_count=0 immediately.
REQ-024 Reset mid-packet SHALL write nothing further and count no error.

Configuration
REQ-025 Macro RX_PKT_WRITER_STATS_EN defined: pkt_count/err_count behave per REQ-017/020.
REQ-026 Macro RX_PKT_WRITER_STATS_EN undefined: both ports SHALL remain present and tie to 0, with counter logic removed; all other behaviour unchanged.

Structure
REQ-027 Shared package rx_pkt_pkg SHALL hold the FSM state enum, pixel width (12), address width (16) and the default PIX_PER_PKT.
REQ-028 One sub-module rx_pix_pack SHALL hold the even/odd pairing register and the write-strobe generation.

Verification
REQ-029 Header, rx_add=0x0012, 16 pixels 0x001..0x010: 8 writes, addr {0x0012,0..7}, first wdata 0x002001; line_done once; line_addr=0x0012; pkt_count=1.
REQ-030 Header, address, then 5 pixels, then 4096 idle cycles: 2 writes, 5th pixel not written, err_count=1, no line_done.
REQ-031 frame_sync rises during HDR: one frame_start pulse; a second rise in the same HDR gives no pulse.
REQ-032 New rx_header rise after pixel 9: err_count=1; next packet completes normally with its own address.
REQ-033 rstn asserted after pixel 7: all outputs 0 within the reset; next full packet writes 8 words, err_count=0.
REQ-034 With RX_PKT_WRITER_STATS_EN undefined, rerun REQ-029/030: pkt_count=err_count=0, writes identical.
